mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter_arb_prio_starve.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data bus memory arbiter: FSM state
// encoding and the encoding of which master owns the current transaction.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the ibus/dbus master handshakes and the single memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              I_ibus_req;
  logic              I_ibus_we;
  logic [ADDR_W-1:0] I_ibus_addr;
  logic [DATA_W-1:0] I_ibus_data;
  logic [MASK_W-1:0] I_ibus_mask;
  logic [DATA_W-1:0] O_ibus_data;
  logic              O_ibus_ready;

  logic              I_dbus_req;
  logic              I_dbus_we;
  logic [ADDR_W-1:0] I_dbus_addr;
  logic [DATA_W-1:0] I_dbus_data;
  logic [MASK_W-1:0] I_dbus_mask;
  logic [DATA_W-1:0] O_dbus_data;
  logic              O_dbus_ready;

  logic              O_mem_req;
  logic              O_mem_we;
  logic [ADDR_W-1:0] O_mem_addr;
  logic [DATA_W-1:0] O_mem_data;
  logic [MASK_W-1:0] O_mem_mask;
  logic              I_mem_gnt;
  logic              I_mem_rvalid;
  logic [DATA_W-1:0] I_mem_rdata;

  logic              O_busy;

  modport slave (
    input  I_ibus_req, I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask,
    output O_ibus_data, O_ibus_ready,
    input  I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
    output O_dbus_data, O_dbus_ready,
    output O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
    input  I_mem_gnt, I_mem_rvalid, I_mem_rdata,
    output O_busy
  );

  modport master (
    output I_ibus_req, I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask,
    input  O_ibus_data, O_ibus_ready,
    output I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
    input  O_dbus_data, O_dbus_ready,
    input  O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
    output I_mem_gnt, I_mem_rvalid, I_mem_rdata,
    input  O_busy
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_prio_starve.sv
// Combinational arbitration: dbus has priority, but ibus is forced through
// once it has lost STARVE_MAX consecutive contested decisions.
module arb_prio_starve
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             ibus_req,
  input  logic             dbus_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             win,
  output owner_e           owner,
  output logic [CNT_W-1:0] starve_cnt_nxt
);

  always_comb begin
    win            = ibus_req | dbus_req;
    owner          = OWN_D;
    starve_cnt_nxt = starve_cnt;
    if (ibus_req && dbus_req) begin
      if (starve_cnt == CNT_W'(STARVE_MAX)) begin
        owner          = OWN_I;
        starve_cnt_nxt = '0;
      end else begin
        owner          = OWN_D;
        starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
    end else if (ibus_req) begin
      owner          = OWN_I;
      starve_cnt_nxt = '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/gnt + rvalid memory port between ibus and dbus, one
// transaction outstanding, with a DONE cycle so masters can drop or renew.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] ibus_rdata_q, ibus_rdata_d;
  logic [DATA_W-1:0] dbus_rdata_q, dbus_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic              arb_win;
  owner_e            arb_owner;
  logic [CNT_W-1:0]  arb_cnt_nxt;

  arb_prio_starve #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_arb (
    .ibus_req       (bus.I_ibus_req),
    .dbus_req       (bus.I_dbus_req),
    .starve_cnt     (starve_cnt_q),
    .win            (arb_win),
    .owner          (arb_owner),
    .starve_cnt_nxt (arb_cnt_nxt)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    ibus_rdata_d = ibus_rdata_q;
    dbus_rdata_d = dbus_rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        // Master fields are sampled only here; after this the command is frozen.
        if (arb_win) begin
          owner_d      = arb_owner;
          starve_cnt_d = arb_cnt_nxt;
          state_d      = REQ;
          if (arb_owner == OWN_D) begin
            we_d    = bus.I_dbus_we;
            addr_d  = bus.I_dbus_addr;
            wdata_d = bus.I_dbus_data;
            mask_d  = bus.I_dbus_mask;
          end else begin
            we_d    = bus.I_ibus_we;
            addr_d  = bus.I_ibus_addr;
            wdata_d = bus.I_ibus_data;
            mask_d  = bus.I_ibus_mask;
          end
        end
      end
      REQ: begin
        if (bus.I_mem_gnt) begin
          if (bus.I_mem_rvalid) begin
            state_d = DONE;
            if (owner_q == OWN_D) dbus_rdata_d = bus.I_mem_rdata;
            else                  ibus_rdata_d = bus.I_mem_rdata;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.I_mem_rvalid) begin
          state_d = DONE;
          if (owner_q == OWN_D) dbus_rdata_d = bus.I_mem_rdata;
          else                  ibus_rdata_d = bus.I_mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      ibus_rdata_q <= '0;
      dbus_rdata_q <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      ibus_rdata_q <= ibus_rdata_d;
      dbus_rdata_q <= dbus_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.O_mem_req    = (state_q == REQ);
  assign bus.O_mem_we     = we_q;
  assign bus.O_mem_addr   = addr_q;
  assign bus.O_mem_data   = wdata_q;
  assign bus.O_mem_mask   = mask_q;
  assign bus.O_ibus_data  = ibus_rdata_q;
  assign bus.O_dbus_data  = dbus_rdata_q;
  assign bus.O_ibus_ready = (state_q == DONE) && (owner_q == OWN_I);
  assign bus.O_dbus_ready = (state_q == DONE) && (owner_q == OWN_D);
  assign bus.O_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of masters, arbitration and memory.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MASK_W     = 4;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  mem_bus_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MASK_W     (MASK_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.I_ibus_req = 0; bus.I_ibus_we = 0; bus.I_ibus_addr = '0;
    bus.I_ibus_data = '0; bus.I_ibus_mask = '0;
    bus.I_dbus_req = 0; bus.I_dbus_we = 0; bus.I_dbus_addr = '0;
    bus.I_dbus_data = '0; bus.I_dbus_mask = '0;
    bus.I_mem_gnt = 0; bus.I_mem_rvalid = 0; bus.I_mem_rdata = '0;
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step(); step();
    total++; if (bus.O_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.O_busy); else passed++;
    total++; if (bus.O_mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.O_mem_req); else passed++;
    total++; if ({bus.O_ibus_ready, bus.O_dbus_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b want 00", {bus.O_ibus_ready, bus.O_dbus_ready}); else passed++;
    total++; if ({bus.O_ibus_data, bus.O_dbus_data} !== 64'h0)
      $display("FAIL reset_data: got %h want 0", {bus.O_ibus_data, bus.O_dbus_data}); else passed++;
    total++; if ({bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data, bus.O_mem_mask} !== '0)
      $display("FAIL reset_cmd: got addr %h data %h want 0", bus.O_mem_addr, bus.O_mem_data); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_ibus_read();
    bus.I_ibus_req = 1; bus.I_ibus_we = 0; bus.I_ibus_addr = 32'h8000_0000;
    step();
    total++; if (bus.O_mem_req !== 1'b1 || bus.O_mem_addr !== 32'h8000_0000 || bus.O_mem_we !== 1'b0)
      $display("FAIL ird_cmd: got req %b addr %h we %b want 1 80000000 0", bus.O_mem_req, bus.O_mem_addr, bus.O_mem_we);
    else passed++;
    bus.I_mem_gnt = 1; bus.I_mem_rvalid = 1; bus.I_mem_rdata = 32'h0000_0413;
    step();
    total++; if (bus.O_ibus_ready !== 1'b1) $display("FAIL ird_ready: got %b want 1", bus.O_ibus_ready); else passed++;
    total++; if (bus.O_ibus_data !== 32'h0000_0413) $display("FAIL ird_data: got %h want 00000413", bus.O_ibus_data); else passed++;
    total++; if (bus.O_dbus_ready !== 1'b0) $display("FAIL ird_dready: got %b want 0", bus.O_dbus_ready); else passed++;
    idle_inputs();
    step();
    total++; if ({bus.O_ibus_ready, bus.O_dbus_ready, bus.O_busy} !== 3'b000)
      $display("FAIL ird_after: got %b want 000", {bus.O_ibus_ready, bus.O_dbus_ready, bus.O_busy}); else passed++;
  endtask

  task automatic test_dbus_write();
    int pulses = 0;
    bus.I_dbus_req = 1; bus.I_dbus_we = 1; bus.I_dbus_addr = 32'h8000_0100;
    bus.I_dbus_data = 32'hDEAD_BEEF; bus.I_dbus_mask = 4'b0011;
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.O_mem_req !== 1'b1 || bus.O_mem_we !== 1'b1 || bus.O_mem_addr !== 32'h8000_0100 ||
          bus.O_mem_data !== 32'hDEAD_BEEF || bus.O_mem_mask !== 4'b0011)
        $display("FAIL dwr_cmd_%0d: got req %b we %b addr %h data %h mask %b want 1 1 80000100 deadbeef 0011",
                 k, bus.O_mem_req, bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data, bus.O_mem_mask);
      else passed++;
      if (bus.O_dbus_ready) pulses++;
      if (k == 2) bus.I_mem_gnt = 1;
      step();
    end
    bus.I_mem_gnt = 0;
    total++; if (bus.O_mem_req !== 1'b0 || bus.O_busy !== 1'b1)
      $display("FAIL dwr_resp: got req %b busy %b want 0 1", bus.O_mem_req, bus.O_busy); else passed++;
    if (bus.O_dbus_ready) pulses++;
    step();
    if (bus.O_dbus_ready) pulses++;
    bus.I_mem_rvalid = 1; bus.I_mem_rdata = 32'h0000_00AC;
    step();
    total++; if (bus.O_dbus_ready !== 1'b1) $display("FAIL dwr_ready: got %b want 1", bus.O_dbus_ready); else passed++;
    total++; if (bus.O_dbus_data !== 32'h0000_00AC) $display("FAIL dwr_data: got %h want 000000ac", bus.O_dbus_data); else passed++;
    total++; if (bus.O_ibus_data !== 32'h0000_0413 || bus.O_ibus_ready !== 1'b0)
      $display("FAIL dwr_ibus_hold: got %h rdy %b want 00000413 0", bus.O_ibus_data, bus.O_ibus_ready); else passed++;
    if (bus.O_dbus_ready) pulses++;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.O_dbus_ready) pulses++;
    end
    total++; if (pulses != 1) $display("FAIL dwr_pulses: got %0d want 1", pulses); else passed++;
  endtask

  task automatic test_spurious();
    bus.I_mem_rvalid = 1; bus.I_mem_rdata = 32'hBAD0_BAD0;
    step();
    bus.I_mem_rvalid = 0;
    total++; if ({bus.O_busy, bus.O_ibus_ready, bus.O_dbus_ready} !== 3'b000)
      $display("FAIL spur_idle: got %b want 000", {bus.O_busy, bus.O_ibus_ready, bus.O_dbus_ready}); else passed++;
    step();
    total++; if (bus.O_busy !== 1'b0 || bus.O_ibus_data !== 32'h0000_0413)
      $display("FAIL spur_idle_hold: got busy %b data %h want 0 00000413", bus.O_busy, bus.O_ibus_data); else passed++;
    bus.I_ibus_req = 1; bus.I_ibus_addr = 32'h8000_0004;
    step();
    bus.I_mem_gnt = 1;
    step();
    bus.I_mem_gnt = 1;
    step();
    bus.I_mem_gnt = 0;
    total++; if (bus.O_busy !== 1'b1 || bus.O_mem_req !== 1'b0 || bus.O_ibus_ready !== 1'b0)
      $display("FAIL spur_resp_gnt: got busy %b req %b rdy %b want 1 0 0", bus.O_busy, bus.O_mem_req, bus.O_ibus_ready);
    else passed++;
    bus.I_mem_rvalid = 1; bus.I_mem_rdata = 32'h1234_5678;
    step();
    total++; if (bus.O_ibus_ready !== 1'b1 || bus.O_ibus_data !== 32'h1234_5678)
      $display("FAIL spur_done: got rdy %b data %h want 1 12345678", bus.O_ibus_ready, bus.O_ibus_data); else passed++;
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    bus.I_dbus_req = 1; bus.I_dbus_we = 0; bus.I_dbus_addr = 32'h8000_0200;
    step();
    bus.I_mem_gnt = 1;
    step();
    bus.I_mem_gnt = 0;
    rst = 1'b0;
    #1;
    total++; if ({bus.O_busy, bus.O_mem_req, bus.O_ibus_ready, bus.O_dbus_ready} !== 4'b0000)
      $display("FAIL rmid_ctrl: got %b want 0000", {bus.O_busy, bus.O_mem_req, bus.O_ibus_ready, bus.O_dbus_ready});
    else passed++;
    total++; if ({bus.O_ibus_data, bus.O_dbus_data, bus.O_mem_addr} !== '0)
      $display("FAIL rmid_data: got i %h d %h a %h want 0", bus.O_ibus_data, bus.O_dbus_data, bus.O_mem_addr); else passed++;
    idle_inputs();
    step();
    rst = 1'b1;
    step();
    bus.I_mem_rvalid = 1; bus.I_mem_rdata = 32'hFEED_F00D;
    step();
    bus.I_mem_rvalid = 0;
    total++; if ({bus.O_busy, bus.O_ibus_ready, bus.O_dbus_ready} !== 3'b000 || bus.O_dbus_data !== 32'h0)
      $display("FAIL rmid_after: got %b data %h want 000 0", {bus.O_busy, bus.O_ibus_ready, bus.O_dbus_ready}, bus.O_dbus_data);
    else passed++;
    step();
    total++; if (bus.O_busy !== 1'b0) $display("FAIL rmid_idle: got %b want 0", bus.O_busy); else passed++;
  endtask

  task automatic test_no_dup();
    int issues = 0, readies = 0;
    bit prev_req = 0, drop_next = 0;
    bus.I_ibus_req = 1; bus.I_ibus_addr = 32'h8000_0008;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.O_mem_req && !prev_req) issues++;
      prev_req = bus.O_mem_req;
      if (drop_next) begin bus.I_ibus_req = 0; drop_next = 0; end
      if (bus.O_ibus_ready) begin readies++; drop_next = 1; end
      bus.I_mem_gnt = bus.O_mem_req; bus.I_mem_rvalid = bus.O_mem_req; bus.I_mem_rdata = 32'h0000_0033;
    end
    total++; if (issues != 1) $display("FAIL nodup_issues: got %0d want 1", issues); else passed++;
    total++; if (readies != 1) $display("FAIL nodup_ready: got %0d want 1", readies); else passed++;
    idle_inputs();
    step();
  endtask

  task automatic test_starve();
    int skips = 0, grants = 0, cyc = 0;
    int got, want;
    idle_inputs();
    rst = 1'b0; step(); rst = 1'b1;
    bus.I_ibus_req = 1; bus.I_ibus_addr = 32'h8000_0010;
    bus.I_dbus_req = 1; bus.I_dbus_addr = 32'h8000_0020;
    while (grants < 15 && cyc < 200) begin
      step();
      cyc++;
      if (bus.O_ibus_ready || bus.O_dbus_ready) begin
        got = bus.O_dbus_ready ? 1 : 0;
        if (skips == STARVE_MAX) begin want = 0; skips = 0; end
        else begin want = 1; skips++; end
        total++; if (got != want || (bus.O_ibus_ready && bus.O_dbus_ready))
          $display("FAIL starve_grant_%0d: got %s want %s", grants, got ? "D" : "I", want ? "D" : "I");
        else passed++;
        grants++;
      end
      bus.I_mem_gnt = bus.O_mem_req; bus.I_mem_rvalid = bus.O_mem_req; bus.I_mem_rdata = $urandom;
    end
    total++; if (grants != 15) $display("FAIL starve_timeout: got %0d grants want 15", grants); else passed++;
    idle_inputs();
    step(); step();
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] rsp_mem [16];
    bit          pend [2];
    logic        we_m [2];
    logic [3:0]  idx_m [2];
    logic [31:0] data_m [2];
    logic [3:0]  mask_m [2];
    logic [31:0] exp_data [2];
    logic [31:0] pend_val;
    bit          active = 0, rv_pend = 0, rdy, drove_rv;
    int          own = 0, w, skips = 0, gnt_wait = 0, rv_wait = 0, rv_cnt = 0, done_cnt = 0;
    logic [3:0]  rsp_idx;
    logic [31:0] dout, exp_addr;

    idle_inputs();
    rst = 1'b0; step(); rst = 1'b1;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; rsp_mem[i] = ref_mem[i]; end
    for (int b = 0; b < 2; b++) begin
      pend[b] = 0; we_m[b] = 0; idx_m[b] = 0; data_m[b] = 0; mask_m[b] = 0; exp_data[b] = 0;
    end
    pend_val = 0; rsp_idx = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      total++; if (bus.O_ibus_ready && bus.O_dbus_ready) $display("FAIL rand_both_ready at %0d", cyc); else passed++;
      for (int b = 0; b < 2; b++) begin
        rdy  = (b == 0) ? bus.O_ibus_ready : bus.O_dbus_ready;
        dout = (b == 0) ? bus.O_ibus_data : bus.O_dbus_data;
        if (rdy) begin
          total++; if (!active || own != b)
            $display("FAIL rand_ready_owner: bus %0d ready, active %0d owner %0d", b, active, own);
          else passed++;
          exp_data[b] = pend_val;
          active = 0; pend[b] = 0; done_cnt++;
        end
        total++; if (dout !== exp_data[b])
          $display("FAIL rand_data_bus%0d at %0d: got %h want %h", b, cyc, dout, exp_data[b]);
        else passed++;
      end

      if (bus.O_mem_req && !active) begin
        w = -1;
        if (pend[0] && pend[1]) begin
          if (skips == STARVE_MAX) begin w = 0; skips = 0; end
          else begin w = 1; skips++; end
        end else if (pend[0]) begin w = 0; skips = 0; end
        else if (pend[1]) w = 1;
        total++;
        if (w < 0) begin
          $display("FAIL rand_issue_noreq at %0d: got mem_req 1 want 0", cyc);
          w = 1;
        end else begin
          exp_addr = 32'h8000_0000 | {26'd0, idx_m[w], 2'b00};
          if (bus.O_mem_we !== we_m[w] || bus.O_mem_addr !== exp_addr ||
              bus.O_mem_data !== data_m[w] || bus.O_mem_mask !== mask_m[w])
            $display("FAIL rand_issue_cmd bus%0d: got we %b addr %h data %h mask %b want %b %h %h %b",
                     w, bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data, bus.O_mem_mask,
                     we_m[w], exp_addr, data_m[w], mask_m[w]);
          else passed++;
        end
        active = 1; own = w;
        if (we_m[w]) begin
          ref_mem[idx_m[w]] = merge(ref_mem[idx_m[w]], data_m[w], mask_m[w]);
          pend_val = $urandom;
        end else begin
          pend_val = ref_mem[idx_m[w]];
        end
        gnt_wait = $urandom_range(0, 3);
        rv_wait  = $urandom_range(0, 2);
      end

      // Memory responder: its own copy of memory, fed only by the DUT's command.
      bus.I_mem_gnt = 0; bus.I_mem_rvalid = 0; bus.I_mem_rdata = $urandom;
      drove_rv = 0;
      if (bus.O_mem_req) begin
        if (gnt_wait > 0) gnt_wait--;
        else begin
          bus.I_mem_gnt = 1;
          rsp_idx = bus.O_mem_addr[5:2];
          if (bus.O_mem_we) rsp_mem[rsp_idx] = merge(rsp_mem[rsp_idx], bus.O_mem_data, bus.O_mem_mask);
          if (rv_wait == 0) begin
            bus.I_mem_rvalid = 1; drove_rv = 1;
            bus.I_mem_rdata  = bus.O_mem_we ? pend_val : rsp_mem[rsp_idx];
          end else begin
            rv_pend = 1; rv_cnt = rv_wait;
          end
        end
      end else begin
        if (rv_pend) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            rv_pend = 0;
            bus.I_mem_rvalid = 1; drove_rv = 1;
            bus.I_mem_rdata  = (we_m[own]) ? pend_val : rsp_mem[rsp_idx];
          end
        end
        bus.I_mem_gnt = ($urandom_range(0, 3) == 0);
      end
      if (!drove_rv && !rv_pend && (!bus.O_busy || bus.O_ibus_ready || bus.O_dbus_ready))
        bus.I_mem_rvalid = ($urandom_range(0, 3) == 0);

      for (int b = 0; b < 2; b++) begin
        if (!pend[b] && $urandom_range(0, 2) == 0) begin
          pend[b]   = 1;
          we_m[b]   = $urandom_range(0, 1);
          idx_m[b]  = 4'($urandom_range(0, 15));
          data_m[b] = $urandom;
          mask_m[b] = 4'($urandom_range(0, 15));
        end
      end
      bus.I_ibus_req = pend[0]; bus.I_ibus_we = we_m[0];
      bus.I_ibus_addr = 32'h8000_0000 | {26'd0, idx_m[0], 2'b00};
      bus.I_ibus_data = data_m[0]; bus.I_ibus_mask = mask_m[0];
      bus.I_dbus_req = pend[1]; bus.I_dbus_we = we_m[1];
      bus.I_dbus_addr = 32'h8000_0000 | {26'd0, idx_m[1], 2'b00};
      bus.I_dbus_data = data_m[1]; bus.I_dbus_mask = mask_m[1];
    end
    total++; if (done_cnt < 100) $display("FAIL rand_progress: got %0d completions want >= 100", done_cnt); else passed++;
    idle_inputs();
    step(); step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ibus_read();
    test_dbus_write();
    test_spurious();
    test_reset_mid();
    test_no_dup();
    test_starve();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
